mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 132 +++++++++++++
 tb/tb_mem_wb_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives one data-memory access per load/store instruction,
// stalls upstream until ack or timeout, and registers the register-file writeback.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] alu_in,
    input  logic        we_in,
    input  logic [3:0]  dst_addr_in,
    input  logic        Mem_re_in,
    input  logic        Mem_we_in,
    input  logic [1:0]  Mem_sel_in,
    input  logic [15:0] d_addr_in,
    input  logic [15:0] wrt_data_in,
    input  logic [15:0] accel_data_in,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        mem_stall,
    output logic        rf_we,
    output logic [3:0]  rf_dst_addr,
    output logic [15:0] rf_wdata,
    input  logic        err_clr,
    output logic        err_timeout
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  count;
    logic        access_in;
    logic        timeout_hit;
    logic        wb_enable;
    logic [15:0] wb_data;

    assign access_in   = Mem_re_in | Mem_we_in;
    assign timeout_hit = (state == ACCESS) && (count == 8'(TIMEOUT - 1)) && !dmem_ack;

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (access_in) begin
                    state_next = ACCESS;
                    mem_stall  = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem_ack || timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rst_n) begin
            mem_stall = 1'b0;
        end
    end

    // A store that also asks for memory data has no read data to write back.
    assign wb_enable = we_in && !timeout_hit && !(Mem_we_in && (Mem_sel_in == 2'b01));

    always_comb begin
        case (Mem_sel_in)
            2'b01:   wb_data = dmem_rdata;
            2'b10:   wb_data = accel_data_in;
            default: wb_data = alu_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 8'd0;
            dmem_req    <= 1'b0;
            dmem_wr     <= 1'b0;
            dmem_addr   <= 16'd0;
            dmem_wdata  <= 16'd0;
            rf_we       <= 1'b0;
            rf_dst_addr <= 4'd0;
            rf_wdata    <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;

            case (state)
                IDLE: begin
                    if (access_in) begin
                        dmem_req   <= 1'b1;
                        dmem_wr    <= Mem_we_in;
                        dmem_addr  <= d_addr_in;
                        dmem_wdata <= wrt_data_in;
                        count      <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack || timeout_hit) begin
                        dmem_req <= 1'b0;
                        dmem_wr  <= 1'b0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase

            // Stalled edges insert a bubble so the held instruction writes only once.
            if (!mem_stall) begin
                rf_we       <= wb_enable;
                rf_dst_addr <= dst_addr_in;
                rf_wdata    <= wb_data;
            end else begin
                rf_we <= 1'b0;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks are queued when an
// instruction is issued and popped whenever the stage raises rf_we.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_in;
    logic        we_in;
    logic [3:0]  dst_addr_in;
    logic        Mem_re_in;
    logic        Mem_we_in;
    logic [1:0]  Mem_sel_in;
    logic [15:0] d_addr_in;
    logic [15:0] wrt_data_in;
    logic [15:0] accel_data_in;
    logic        dmem_req;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        mem_stall;
    logic        rf_we;
    logic [3:0]  rf_dst_addr;
    logic [15:0] rf_wdata;
    logic        err_clr;
    logic        err_timeout;

    int compared   = 0;
    int mismatched = 0;
    logic [19:0] exp_q[$];

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .alu_in(alu_in), .we_in(we_in),
        .dst_addr_in(dst_addr_in), .Mem_re_in(Mem_re_in), .Mem_we_in(Mem_we_in),
        .Mem_sel_in(Mem_sel_in), .d_addr_in(d_addr_in), .wrt_data_in(wrt_data_in),
        .accel_data_in(accel_data_in), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .rf_we(rf_we),
        .rf_dst_addr(rf_dst_addr), .rf_wdata(rf_wdata), .err_clr(err_clr),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            logic [19:0] e;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got dst=%0d data=%h, required no write", rf_dst_addr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_dst_addr, rf_wdata} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL writeback: got dst=%0d data=%h, required dst=%0d data=%h",
                             rf_dst_addr, rf_wdata, e[19:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_in = 16'h0; we_in = 1'b0; dst_addr_in = 4'd0; Mem_re_in = 1'b0;
        Mem_we_in = 1'b0; Mem_sel_in = 2'b00; d_addr_in = 16'h0; wrt_data_in = 16'h0;
        accel_data_in = 16'h0;
    endtask

    task automatic issue(input logic [15:0] alu, input logic we, input logic [3:0] dst,
                         input logic re, input logic mwe, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [15:0] wdata);
        alu_in = alu; we_in = we; dst_addr_in = dst; Mem_re_in = re; Mem_we_in = mwe;
        Mem_sel_in = sel; d_addr_in = addr; wrt_data_in = wdata;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 16'h0; err_clr = 1'b0;
        issue(16'hFFFF, 1'b1, 4'hF, 1'b1, 1'b0, 2'b01, 16'h1111, 16'h2222);
        @(negedge clk);
        check("stall_in_reset", {15'd0, mem_stall}, 16'd0);
        step(); step();
        @(negedge clk);
        check("reset_req", {15'd0, dmem_req}, 16'd0);
        check("reset_wr", {15'd0, dmem_wr}, 16'd0);
        check("reset_addr", dmem_addr, 16'd0);
        check("reset_wdata", dmem_wdata, 16'd0);
        check("reset_rf_we", {15'd0, rf_we}, 16'd0);
        check("reset_rf_dst", {12'd0, rf_dst_addr}, 16'd0);
        check("reset_rf_wdata", rf_wdata, 16'd0);
        check("reset_err", {15'd0, err_timeout}, 16'd0);
        step();
        nop();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        issue(16'h1234, 1'b1, 4'd3, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        exp_q.push_back({4'd3, 16'h1234});
        @(negedge clk);
        check("alu_stall", {15'd0, mem_stall}, 16'd0);
        step();
        issue(16'h0BAD, 1'b1, 4'd8, 1'b0, 1'b0, 2'b10, 16'h0, 16'h0);
        accel_data_in = 16'hACCE;
        exp_q.push_back({4'd8, 16'hACCE});
        @(negedge clk);
        check("accel_stall", {15'd0, mem_stall}, 16'd0);
        step();
        issue(16'h5151, 1'b1, 4'd11, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0);
        exp_q.push_back({4'd11, 16'h5151});
        step();
        issue(16'h9999, 1'b0, 4'd12, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        step();
        nop();
        step();
    endtask

    task automatic test_load();
        int stalls = 0;
        issue(16'h0, 1'b1, 4'd5, 1'b1, 1'b0, 2'b01, 16'h0040, 16'h0);
        exp_q.push_back({4'd5, 16'hBEEF});
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
            end
            @(negedge clk);
            if (mem_stall === 1'b1) stalls++;
            if (c == 1) begin
                check("load_req", {15'd0, dmem_req}, 16'd1);
                check("load_wr", {15'd0, dmem_wr}, 16'd0);
                check("load_addr", dmem_addr, 16'h0040);
            end
            step();
        end
        nop();
        dmem_ack = 1'b0; dmem_rdata = 16'h0;
        check("load_stall_cycles", 16'(stalls), 16'd4);
        @(negedge clk);
        check("load_req_done", {15'd0, dmem_req}, 16'd0);
        step();
    endtask

    task automatic store_once(input logic re, input logic we, input logic [3:0] dst,
                              input logic [15:0] alu, input logic [15:0] addr,
                              input logic [15:0] wdata);
        issue(alu, we, dst, re, 1'b1, 2'b00, addr, wdata);
        if (we) exp_q.push_back({dst, alu});
        @(negedge clk);
        check("store_stall_detect", {15'd0, mem_stall}, 16'd1);
        check("store_req_detect", {15'd0, dmem_req}, 16'd0);
        step();
        dmem_ack = 1'b1;
        @(negedge clk);
        check("store_req", {15'd0, dmem_req}, 16'd1);
        check("store_wr", {15'd0, dmem_wr}, 16'd1);
        check("store_addr", dmem_addr, addr);
        check("store_wdata", dmem_wdata, wdata);
        check("store_stall_ack", {15'd0, mem_stall}, 16'd0);
        step();
        nop();
        dmem_ack = 1'b0;
        @(negedge clk);
        check("store_req_done", {15'd0, dmem_req}, 16'd0);
        step();
    endtask

    task automatic test_store();
        store_once(1'b0, 1'b0, 4'd1, 16'h0, 16'h0080, 16'hA5A5);
        store_once(1'b1, 1'b1, 4'd9, 16'h7777, 16'h00C0, 16'h5A5A);
    endtask

    task automatic timeout_once(input logic clr_at_hit);
        int reqs = 0;
        logic s;
        issue(16'h0, 1'b1, 4'd6, 1'b1, 1'b0, 2'b01, 16'h0100, 16'h0);
        for (int c = 0; c < 7; c++) begin
            err_clr = (clr_at_hit && c == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (dmem_req === 1'b1) reqs++;
            s = mem_stall;
            step();
            if (s !== 1'b1) nop();
        end
        err_clr = 1'b0;
        check("timeout_req_cycles", 16'(reqs), 16'd4);
        check("timeout_err", {15'd0, err_timeout}, 16'd1);
    endtask

    task automatic test_timeout();
        timeout_once(1'b0);
        issue(16'h4321, 1'b1, 4'd10, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        exp_q.push_back({4'd10, 16'h4321});
        @(negedge clk);
        check("after_timeout_stall", {15'd0, mem_stall}, 16'd0);
        step();
        nop();
        step();
        check("err_sticky", {15'd0, err_timeout}, 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", {15'd0, err_timeout}, 16'd0);
        timeout_once(1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_access();
        issue(16'h0, 1'b1, 4'd7, 1'b1, 1'b0, 2'b01, 16'h0200, 16'h0);
        step();
        step();
        rst_n = 1'b0;
        nop();
        step();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        check("rst_acc_req", {15'd0, dmem_req}, 16'd0);
        check("rst_acc_stall", {15'd0, mem_stall}, 16'd0);
        check("rst_acc_addr", dmem_addr, 16'd0);
        check("rst_acc_rf_wdata", rf_wdata, 16'd0);
        step();
        dmem_ack = 1'b0; dmem_rdata = 16'h0;
        @(negedge clk);
        check("rst_acc_req_late", {15'd0, dmem_req}, 16'd0);
        check("rst_acc_rf_we_late", {15'd0, rf_we}, 16'd0);
        step();
    endtask

    task automatic test_back_to_back();
        issue(16'h0, 1'b1, 4'd2, 1'b1, 1'b0, 2'b01, 16'h0300, 16'h0);
        exp_q.push_back({4'd2, 16'h1111});
        exp_q.push_back({4'd4, 16'h4444});
        step();
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        step();
        dmem_ack = 1'b0; dmem_rdata = 16'h0;
        issue(16'h4444, 1'b1, 4'd4, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        check("b2b_load_dst", {12'd0, rf_dst_addr}, 16'd2);
        check("b2b_alu_stall", {15'd0, mem_stall}, 16'd0);
        step();
        nop();
        @(negedge clk);
        check("b2b_alu_we", {15'd0, rf_we}, 16'd1);
        check("b2b_alu_dst", {12'd0, rf_dst_addr}, 16'd4);
        step();
        @(negedge clk);
        check("b2b_single_write", {15'd0, rf_we}, 16'd0);
        step();
    endtask

    initial begin
        nop();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_access();
        test_back_to_back();
        step(); step();
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
